aes_wb_frontend: RTL

AES_WB_FRONTEND -- requirements
Module: aes_wb_frontend

---
 rtl/aes_wb_pkg.sv | 48 ++++
 rtl/aes_wb_fifo.sv | 60 ++++++
 rtl/aes_wb_frontend.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/aes_wb_pkg.sv
// Shared definitions for the AES Wishbone front end:
// register word offsets, CTRL/STATUS bit positions, FSM and mode enums.
package aes_wb_pkg;

  localparam logic [5:0] ADR_CTRL   = 6'h00;
  localparam logic [5:0] ADR_STATUS = 6'h01;
  localparam logic [5:0] ADR_DIN0   = 6'h04;
  localparam logic [5:0] ADR_KEY0   = 6'h08;
  localparam logic [5:0] ADR_DOUT0  = 6'h10;
  localparam logic [5:0] ADR_POP    = 6'h14;

  localparam int CTRL_START   = 0;
  localparam int CTRL_DECRYPT = 1;
  localparam int CTRL_MODE    = 2;
  localparam int CTRL_IRQ_EN  = 4;
  localparam int CTRL_FLUSH   = 5;

  localparam int ST_BUSY  = 0;
  localparam int ST_EMPTY = 1;
  localparam int ST_FULL  = 2;
  localparam int ST_OVF   = 3;
  localparam int ST_CNT   = 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT
  } state_e;

  typedef enum logic [1:0] {
    MODE_ECB,
    MODE_CBC,
    MODE_CTR,
    MODE_RSV
  } mode_e;

  function automatic logic [31:0] byte_merge(
    input logic [31:0] old,
    input logic [31:0] wd,
    input logic [3:0]  sel
  );
    logic [31:0] r;
    for (int b = 0; b < 4; b++)
      r[8*b +: 8] = sel[b] ? wd[8*b +: 8] : old[8*b +: 8];
    return r;
  endfunction

endpackage

// File: rtl/aes_wb_fifo.sv
// Synchronous result FIFO: push/pop/flush, head, count, empty/full.
// Ports: clock, reset, push, pop, flush, din -> head, count, empty, full.
module aes_wb_fifo #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rp;
  logic [AW-1:0]    wp;
  logic [AW:0]      cnt;
  logic             do_pop;
  logic             do_push;

  assign empty   = (cnt == '0);
  assign full    = (cnt == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  // a pop in the same cycle frees the slot a full push needs
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rp];
  assign count   = cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rp  <= '0;
      wp  <= '0;
      cnt <= '0;
    end else if (flush) begin
      rp  <= '0;
      wp  <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (do_push & ~flush) mem[wp] <= din;
  end

endmodule

// File: rtl/aes_wb_frontend.sv
// Wishbone slave front end for an AES core: key/data regs, job FSM,
// result FIFO. Optional macro AES_WB_IRQ_EN enables the irq output.
module aes_wb_frontend
  import aes_wb_pkg::*;
#(
  parameter int KEY_WORDS = 8,
  parameter int OUT_DEPTH = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    io_wbs_cyc_i,
  input  logic                    io_wbs_stb_i,
  input  logic                    io_wbs_we_i,
  input  logic [31:0]             io_wbs_adr_i,
  input  logic [31:0]             io_wbs_dat_i,
  input  logic [3:0]              io_wbs_sel_i,
  output logic [31:0]             io_wbs_dat_o,
  output logic                    io_wbs_ack_o,
  output logic                    core_start,
  output logic                    core_decrypt,
  output logic [1:0]              core_mode,
  output logic [32*KEY_WORDS-1:0] core_key,
  output logic [127:0]            core_din,
  input  logic                    core_ready,
  input  logic                    core_done,
  input  logic [127:0]            core_dout,
  output logic                    irq
);

  localparam int CW = $clog2(OUT_DEPTH) + 1;

  state_e state_q, state_d;

  logic [31:0] din_q [4];
  logic [31:0] key_q [KEY_WORDS];
  logic        decrypt_q;
  mode_e       mode_q;
  logic        irq_en_q;
  logic        ovf_q;

  logic [127:0]            din_s;
  logic [32*KEY_WORDS-1:0] key_s;
  logic                    dec_s;
  mode_e                   mode_s;
  logic [32*KEY_WORDS-1:0] key_flat;

  logic [5:0]  wa;
  logic        req, wr;
  logic        is_ctrl, is_status, is_din, is_key, is_dout, is_pop;
  logic        key_ok;
  logic [31:0] ctrl_rd, status_rd, ctrl_wd, rdata;
  logic        go, flush, pop, push, ovf_set, ovf_clr;

  logic [127:0]  head;
  logic [CW-1:0] count;
  logic          empty, full;

  assign wa  = io_wbs_adr_i[7:2];
  assign req = io_wbs_cyc_i & io_wbs_stb_i & ~io_wbs_ack_o;
  assign wr  = req & io_wbs_we_i;

  assign is_ctrl   = (wa == ADR_CTRL);
  assign is_status = (wa == ADR_STATUS);
  assign is_din    = (wa[5:2] == ADR_DIN0[5:2]);
  assign is_key    = (wa[5:3] == ADR_KEY0[5:3]);
  assign is_dout   = (wa[5:2] == ADR_DOUT0[5:2]);
  assign is_pop    = (wa == ADR_POP);
  assign key_ok    = (32'(wa[2:0]) < 32'(KEY_WORDS));

  assign ctrl_rd = {26'b0, 1'b0, irq_en_q, mode_q, decrypt_q, 1'b0};
  assign status_rd = {16'b0, 8'(count), 4'b0,
                      ovf_q, full, empty, (state_q != S_IDLE)};
  // START and DECRYPT/MODE written together: the job sees the new fields
  assign ctrl_wd = byte_merge(ctrl_rd, io_wbs_dat_i, io_wbs_sel_i);

  assign go    = wr & is_ctrl & io_wbs_sel_i[0]
               & io_wbs_dat_i[CTRL_START] & (state_q == S_IDLE);
  assign flush = wr & is_ctrl & io_wbs_sel_i[0] & io_wbs_dat_i[CTRL_FLUSH];
  assign pop   = wr & is_pop;
  assign push  = (state_q == S_WAIT) & core_done;
  assign ovf_set = push & full & ~pop & ~flush;
  assign ovf_clr = wr & is_status & io_wbs_sel_i[0] & io_wbs_dat_i[ST_OVF];

  always_comb begin
    key_flat = '0;
    for (int i = 0; i < KEY_WORDS; i++)
      key_flat[32*i +: 32] = key_q[i];
  end

  always_comb begin
    state_d    = state_q;
    core_start = 1'b0;
    unique case (state_q)
      S_IDLE:  if (go) state_d = S_ISSUE;
      S_ISSUE: if (core_ready) begin
        core_start = 1'b1;
        state_d    = S_WAIT;
      end
      S_WAIT:  if (core_done) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) din_q[i] <= '0;
      for (int i = 0; i < KEY_WORDS; i++) key_q[i] <= '0;
      decrypt_q <= 1'b0;
      mode_q    <= MODE_ECB;
      din_s     <= '0;
      key_s     <= '0;
      dec_s     <= 1'b0;
      mode_s    <= MODE_ECB;
      ovf_q     <= 1'b0;
    end else begin
      if (wr & is_ctrl) begin
        decrypt_q <= ctrl_wd[CTRL_DECRYPT];
        mode_q    <= mode_e'(ctrl_wd[CTRL_MODE +: 2]);
      end
      if (wr & is_din)
        din_q[wa[1:0]] <= byte_merge(din_q[wa[1:0]],
                                     io_wbs_dat_i, io_wbs_sel_i);
      if (wr & is_key & key_ok)
        key_q[wa[2:0]] <= byte_merge(key_q[wa[2:0]],
                                     io_wbs_dat_i, io_wbs_sel_i);
      if (go) begin
        din_s  <= {din_q[3], din_q[2], din_q[1], din_q[0]};
        key_s  <= key_flat;
        dec_s  <= ctrl_wd[CTRL_DECRYPT];
        mode_s <= mode_e'(ctrl_wd[CTRL_MODE +: 2]);
      end
      ovf_q <= ovf_set | (ovf_q & ~ovf_clr);
    end
  end

`ifdef AES_WB_IRQ_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      irq_en_q <= 1'b0;
      irq      <= 1'b0;
    end else begin
      if (wr & is_ctrl) irq_en_q <= ctrl_wd[CTRL_IRQ_EN];
      irq <= irq_en_q & (~empty | ovf_q);
    end
  end
`else
  assign irq_en_q = 1'b0;
  assign irq      = 1'b0;
`endif

  always_comb begin
    rdata = '0;
    unique case (1'b1)
      is_ctrl:   rdata = ctrl_rd;
      is_status: rdata = status_rd;
      is_din:    rdata = din_q[wa[1:0]];
      is_key:    rdata = key_ok ? key_q[wa[2:0]] : '0;
      is_dout:   rdata = empty ? '0 : head[32*wa[1:0] +: 32];
      default:   rdata = '0;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      io_wbs_ack_o <= 1'b0;
      io_wbs_dat_o <= '0;
    end else begin
      io_wbs_ack_o <= req;
      io_wbs_dat_o <= req ? rdata : '0;
    end
  end

  aes_wb_fifo #(
    .WIDTH (128),
    .DEPTH (OUT_DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .din   (core_dout),
    .head  (head),
    .count (count),
    .empty (empty),
    .full  (full)
  );

  assign core_decrypt = dec_s;
  assign core_mode    = mode_s;
  assign core_key     = key_s;
  assign core_din     = din_s;

endmodule
